// File: rtl/perf_window_sampler_if.sv
// Register access port of perf_window_sampler.
// The master drives the write/read strobes, address and write data.
// The slave returns rd_data together with a rd_valid pulse one cycle after rd_en.
interface perf_window_sampler_if;
    logic        wr_en;
    logic        rd_en;
    logic [2:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_valid;

    modport master (
        output wr_en,
        output rd_en,
        output addr,
        output wr_data,
        input  rd_data,
        input  rd_valid
    );

    modport slave (
        input  wr_en,
        input  rd_en,
        input  addr,
        input  wr_data,
        output rd_data,
        output rd_valid
    );
endinterface

// File: rtl/perf_window_sampler.sv
// perf_window_sampler
// This block cuts the free-running cycle and instruction counters into windows of
// programmable length. At the end of each window it latches the deltas and
// pulses win_done_o. The CSR/debug path reads the results through the register port.
//
// Register map (32-bit values, zero-extended):
//   0 CTRL     [0]=en [1]=oneshot
//   1 STATUS   [0]=valid [1]=ovf (read-only; a read clears it)
//   2 WIN_LEN  (a write of 0 stores 1)
//   3 WIN_CYC  (read-only)
//   4 WIN_INST (read-only; 0 when the window's net instruction count went negative)
//   5 WIN_NUM  (read-only; saturates at all-ones)
//   6 THRESH   (present only when PERF_IRQ_EN is defined)
//
// Optional feature macro PERF_IRQ_EN:
//   When it is defined, a window whose WIN_INST is below THRESH raises a sticky perf_irq_o.
//   A STATUS read or a CTRL.en=0 write clears it.
//   When it is undefined, perf_irq_o is tied 0 and address 6 behaves as unmapped.
module perf_window_sampler #(
    parameter int CYC_W  = 32,
    parameter int INST_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CYC_W-1:0]     cycle_count_i,
    input  logic [INST_W-1:0]    inst_count_i,
    perf_window_sampler_if.slave bus,
    output logic                 win_done_o,
    output logic                 perf_irq_o
);

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_LEN    = 3'd2;
    localparam logic [2:0] ADDR_CYC    = 3'd3;
    localparam logic [2:0] ADDR_INST   = 3'd4;
    localparam logic [2:0] ADDR_NUM    = 3'd5;
`ifdef PERF_IRQ_EN
    localparam logic [2:0] ADDR_THRESH = 3'd6;
    localparam int         CMP_W       = (INST_W > 32) ? INST_W : 32;
`endif

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN
    } stateT;

    stateT             state_q, state_d;
    logic              ctrlEn_q, ctrlEn_d;
    logic              ctrlOneshot_q, ctrlOneshot_d;
    logic              statValid_q, statValid_d;
    logic              statOvf_q, statOvf_d;
    logic [LEN_W-1:0]  winLen_q, winLen_d;
    logic [CYC_W-1:0]  winCyc_q, winCyc_d;
    logic [INST_W-1:0] winInst_q, winInst_d;
    logic [31:0]       winNum_q, winNum_d;
    logic [CYC_W-1:0]  baseCyc_q, baseCyc_d;
    logic [INST_W-1:0] baseInst_q, baseInst_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       rdData_q, rdData_d;
    logic              rdValid_q, rdValid_d;
    logic              winDone_q, winDone_d;
`ifdef PERF_IRQ_EN
    logic [31:0]       thresh_q, thresh_d;
    logic              perfIrq_q, perfIrq_d;
    logic              irqLow;
`endif

    logic              wrCtrl;
    logic              stopReq;
    logic              statRead;
    logic              complete;
    logic [CYC_W-1:0]  cycDelta;
    logic [INST_W-1:0] instDelta;
    logic [INST_W-1:0] winInstNew;
    logic [LEN_W-1:0]  lenWr;
    logic [31:0]       rdMux;
    logic              unusedBits;

    assign wrCtrl   = bus.wr_en && (bus.addr == ADDR_CTRL);
    assign stopReq  = wrCtrl && !bus.wr_data[0];
    assign statRead = bus.rd_en && (bus.addr == ADDR_STATUS);

    // Modular subtraction keeps the deltas correct when a counter wraps during the window.
    assign cycDelta   = cycle_count_i - baseCyc_q;
    assign instDelta  = inst_count_i - baseInst_q;
    // A negative net instruction count (after a flush) is reported as zero.
    assign winInstNew = instDelta[INST_W-1] ? '0 : instDelta;

    // A disable written on the same cycle as the last window cycle discards that window.
    assign complete = (state_q == RUN) && (cnt_q == '0) && !stopReq;

    assign lenWr      = bus.wr_data[LEN_W-1:0];
    assign unusedBits = ^bus.wr_data;

`ifdef PERF_IRQ_EN
    assign irqLow = CMP_W'(winInstNew) < CMP_W'(thresh_q);
`endif

    // Select the read value from the current register contents.
    // A write on the same cycle therefore does not affect the value returned.
    always_comb begin
        rdMux = '0;
        case (bus.addr)
            ADDR_CTRL:   rdMux = {30'b0, ctrlOneshot_q, ctrlEn_q};
            ADDR_STATUS: rdMux = {30'b0, statOvf_q, statValid_q};
            ADDR_LEN:    rdMux = 32'(winLen_q);
            ADDR_CYC:    rdMux = 32'(winCyc_q);
            ADDR_INST:   rdMux = 32'(winInst_q);
            ADDR_NUM:    rdMux = winNum_q;
`ifdef PERF_IRQ_EN
            ADDR_THRESH: rdMux = thresh_q;
`endif
            default:     rdMux = '0;
        endcase
    end

    // Compute the next state: register writes, the window FSM, result latching and status bookkeeping.
    always_comb begin
        state_d       = state_q;
        ctrlEn_d      = ctrlEn_q;
        ctrlOneshot_d = ctrlOneshot_q;
        statValid_d   = statValid_q;
        statOvf_d     = statOvf_q;
        winLen_d      = winLen_q;
        winCyc_d      = winCyc_q;
        winInst_d     = winInst_q;
        winNum_d      = winNum_q;
        baseCyc_d     = baseCyc_q;
        baseInst_d    = baseInst_q;
        cnt_d         = cnt_q;
        rdValid_d     = bus.rd_en;
        rdData_d      = bus.rd_en ? rdMux : 32'b0;
        winDone_d     = complete;
`ifdef PERF_IRQ_EN
        thresh_d      = thresh_q;
        perfIrq_d     = perfIrq_q;
`endif

        if (wrCtrl) begin
            ctrlEn_d      = bus.wr_data[0];
            ctrlOneshot_d = bus.wr_data[1];
        end
        if (bus.wr_en && (bus.addr == ADDR_LEN)) begin
            winLen_d = (lenWr == '0) ? LEN_W'(1) : lenWr;
        end
`ifdef PERF_IRQ_EN
        if (bus.wr_en && (bus.addr == ADDR_THRESH)) begin
            thresh_d = bus.wr_data;
        end
`endif

        case (state_q)
            IDLE: begin
                if (wrCtrl && bus.wr_data[0]) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (stopReq) begin
                    state_d = IDLE;
                end else begin
                    baseCyc_d  = cycle_count_i;
                    baseInst_d = inst_count_i;
                    cnt_d      = winLen_q - LEN_W'(1);
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (stopReq) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    if (ctrlOneshot_q) begin
                        ctrlEn_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        baseCyc_d  = cycle_count_i;
                        baseInst_d = inst_count_i;
                        cnt_d      = winLen_q - LEN_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            winCyc_d  = cycDelta;
            winInst_d = winInstNew;
            if (winNum_q != '1) begin
                winNum_d = winNum_q + 32'd1;
            end
        end

        if (statRead) begin
            statValid_d = 1'b0;
            statOvf_d   = 1'b0;
        end
        if (complete) begin
            statValid_d = 1'b1;
            if (statValid_q && !statRead) begin
                statOvf_d = 1'b1;
            end
        end

`ifdef PERF_IRQ_EN
        if (statRead || stopReq) begin
            perfIrq_d = 1'b0;
        end
        if (complete && irqLow) begin
            perfIrq_d = 1'b1;
        end
`endif
    end

    // Register all state. An asynchronous reset returns everything to idle defaults immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ctrlEn_q      <= 1'b0;
            ctrlOneshot_q <= 1'b0;
            statValid_q   <= 1'b0;
            statOvf_q     <= 1'b0;
            winLen_q      <= LEN_W'(1);
            winCyc_q      <= '0;
            winInst_q     <= '0;
            winNum_q      <= '0;
            baseCyc_q     <= '0;
            baseInst_q    <= '0;
            cnt_q         <= '0;
            rdData_q      <= '0;
            rdValid_q     <= 1'b0;
            winDone_q     <= 1'b0;
`ifdef PERF_IRQ_EN
            thresh_q      <= '0;
            perfIrq_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            ctrlEn_q      <= ctrlEn_d;
            ctrlOneshot_q <= ctrlOneshot_d;
            statValid_q   <= statValid_d;
            statOvf_q     <= statOvf_d;
            winLen_q      <= winLen_d;
            winCyc_q      <= winCyc_d;
            winInst_q     <= winInst_d;
            winNum_q      <= winNum_d;
            baseCyc_q     <= baseCyc_d;
            baseInst_q    <= baseInst_d;
            cnt_q         <= cnt_d;
            rdData_q      <= rdData_d;
            rdValid_q     <= rdValid_d;
            winDone_q     <= winDone_d;
`ifdef PERF_IRQ_EN
            thresh_q      <= thresh_d;
            perfIrq_q     <= perfIrq_d;
`endif
        end
    end

    assign bus.rd_data  = rdData_q;
    assign bus.rd_valid = rdValid_q;
    assign win_done_o   = winDone_q;
`ifdef PERF_IRQ_EN
    assign perf_irq_o   = perfIrq_q;
`else
    assign perf_irq_o   = 1'b0;
`endif

endmodule

// File: tb/tb_perf_window_sampler.sv
// Directed testbench for perf_window_sampler.
// Each test task drives a scenario and compares the DUT against hand-computed values.
module tb_perf_window_sampler;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cycCount;
    logic [31:0] instCount;
    logic        winDone;
    logic        perfIrq;

    int total = 0;
    int bad = 0;
    int doneCount = 0;
    int instMode;
    bit instPhase;

    perf_window_sampler_if bus ();

    perf_window_sampler dut (
        .clk           (clk),
        .rst           (rst),
        .cycle_count_i (cycCount),
        .inst_count_i  (instCount),
        .bus           (bus),
        .win_done_o    (winDone),
        .perf_irq_o    (perfIrq)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // Count every win_done pulse, sampling midway between active edges.
    always @(negedge clk) begin
        if (winDone === 1'b1) doneCount++;
    end

    // Advance one clock, then move the counters for the next cycle.
    // instMode: 0 hold, 1 +1 per cycle, 2 +1 every second cycle.
    task automatic nextCycle();
        @(posedge clk);
        #1;
        cycCount = cycCount + 32'd1;
        case (instMode)
            1: instCount = instCount + 32'd1;
            2: begin
                if (instPhase) instCount = instCount + 32'd1;
                instPhase = !instPhase;
            end
            default: ;
        endcase
    endtask

    task automatic regWrite(input logic [2:0] a, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.addr    = a;
        bus.wr_data = d;
        nextCycle();
        bus.wr_en   = 1'b0;
    endtask

    task automatic regRead(input logic [2:0] a, output logic [31:0] d, output logic v);
        bus.rd_en = 1'b1;
        bus.addr  = a;
        nextCycle();
        d = bus.rd_data;
        v = bus.rd_valid;
        bus.rd_en = 1'b0;
    endtask

    // Wait for win_done. The result is the number of cycles waited, or -1 on timeout.
    task automatic waitDone(input int maxCyc, output int lat);
        lat = -1;
        for (int i = 1; i <= maxCyc && lat < 0; i++) begin
            nextCycle();
            if (winDone === 1'b1) lat = i;
        end
    endtask

    task automatic resetDut();
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.addr    = 3'd0;
        bus.wr_data = 32'd0;
        instMode    = 1;
        instPhase   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        logic        rv;
        logic [31:0] expv [8] = '{32'd0, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
        resetDut();
        total++;
        if ({winDone, perfIrq, bus.rd_valid} !== 3'b000 || bus.rd_data !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got done=%b irq=%b rv=%b rd=%h want all 0",
                     winDone, perfIrq, bus.rd_valid, bus.rd_data);
        end
        for (int a = 0; a < 8; a++) begin
            regRead(3'(a), v, rv);
            total++;
            if (v !== expv[a] || rv !== 1'b1) begin
                bad++;
                $display("[TB] FAIL reset_reg%0d: got %h valid=%b want %h valid=1", a, v, rv, expv[a]);
            end
        end
    endtask

    task automatic test_regmap();
        logic [31:0] v;
        logic        rv;
        resetDut();
        regWrite(3'd2, 32'd0);
        regRead(3'd2, v, rv);
        total++;
        if (v !== 32'd1) begin bad++; $display("[TB] FAIL len_zero: got %h want 1", v); end
        regWrite(3'd3, 32'h1234);
        regRead(3'd3, v, rv);
        total++;
        if (v !== 32'd0) begin bad++; $display("[TB] FAIL ro_write: got %h want 0", v); end
        bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.addr = 3'd2; bus.wr_data = 32'd7;
        nextCycle();
        bus.wr_en = 1'b0; bus.rd_en = 1'b0;
        v = bus.rd_data;
        total++;
        if (v !== 32'd1) begin bad++; $display("[TB] FAIL rw_same_cycle: got %h want 1", v); end
        nextCycle();
        total++;
        if (bus.rd_valid !== 1'b0) begin bad++; $display("[TB] FAIL rd_valid_pulse: got %b want 0", bus.rd_valid); end
        regRead(3'd2, v, rv);
        total++;
        if (v !== 32'd7) begin bad++; $display("[TB] FAIL rw_after: got %h want 7", v); end
        regWrite(3'd6, 32'h55);
        regRead(3'd6, v, rv);
        total++;
`ifdef PERF_IRQ_EN
        if (v !== 32'h55) begin bad++; $display("[TB] FAIL thresh_rw: got %h want 55", v); end
`else
        if (v !== 32'h0) begin bad++; $display("[TB] FAIL addr6_unmapped: got %h want 0", v); end
`endif
    endtask

    task automatic test_oneshot();
        logic [31:0] v;
        logic        rv;
        int          lat;
        int          d0;
        resetDut();
        regWrite(3'd2, 32'd10);
        regWrite(3'd0, 32'd3);
        waitDone(30, lat);
        total++;
        if (lat !== 11) begin bad++; $display("[TB] FAIL oneshot_latency: got %0d want 11", lat); end
        nextCycle();
        total++;
        if (winDone !== 1'b0) begin bad++; $display("[TB] FAIL oneshot_pulse_width: got %b want 0", winDone); end
        d0 = doneCount;
        repeat (15) nextCycle();
        total++;
        if (doneCount !== d0) begin bad++; $display("[TB] FAIL oneshot_extra_done: got %0d want %0d", doneCount, d0); end
        regRead(3'd0, v, rv);
        total++;
        if (v !== 32'h2) begin bad++; $display("[TB] FAIL oneshot_ctrl: got %h want 2", v); end
        regRead(3'd3, v, rv);
        total++;
        if (v !== 32'd10) begin bad++; $display("[TB] FAIL oneshot_win_cyc: got %h want a", v); end
        regRead(3'd4, v, rv);
        total++;
        if (v !== 32'd10) begin bad++; $display("[TB] FAIL oneshot_win_inst: got %h want a", v); end
        regRead(3'd5, v, rv);
        total++;
        if (v !== 32'd1) begin bad++; $display("[TB] FAIL oneshot_win_num: got %h want 1", v); end
        regRead(3'd1, v, rv);
        total++;
        if (v !== 32'h1) begin bad++; $display("[TB] FAIL oneshot_status: got %h want 1", v); end
        regRead(3'd1, v, rv);
        total++;
        if (v !== 32'h0) begin bad++; $display("[TB] FAIL oneshot_status_clear: got %h want 0", v); end
    endtask

    task automatic test_continuous();
        logic [31:0] v;
        logic        rv;
        int          lat;
        int          d0;
        resetDut();
        instMode = 2;
        regWrite(3'd2, 32'd4);
        d0 = doneCount;
        regWrite(3'd0, 32'd1);
        waitDone(20, lat);
        total++;
        if (lat !== 5) begin bad++; $display("[TB] FAIL cont_first: got %0d want 5", lat); end
        regWrite(3'd2, 32'd6);
        waitDone(20, lat);
        total++;
        if (lat !== 3) begin bad++; $display("[TB] FAIL cont_second: got %0d want 3", lat); end
        waitDone(20, lat);
        total++;
        if (lat !== 6) begin bad++; $display("[TB] FAIL cont_new_len: got %0d want 6", lat); end
        regWrite(3'd0, 32'd0);
        repeat (10) nextCycle();
        total++;
        if (doneCount - d0 !== 3) begin bad++; $display("[TB] FAIL cont_count: got %0d want 3", doneCount - d0); end
        regRead(3'd3, v, rv);
        total++;
        if (v !== 32'd6) begin bad++; $display("[TB] FAIL cont_win_cyc: got %h want 6", v); end
        regRead(3'd4, v, rv);
        total++;
        if (v !== 32'd3) begin bad++; $display("[TB] FAIL cont_win_inst: got %h want 3", v); end
        regRead(3'd5, v, rv);
        total++;
        if (v !== 32'd3) begin bad++; $display("[TB] FAIL cont_win_num: got %h want 3", v); end
        regRead(3'd1, v, rv);
        total++;
        if (v !== 32'h3) begin bad++; $display("[TB] FAIL cont_status_ovf: got %h want 3", v); end
        regRead(3'd1, v, rv);
        total++;
        if (v !== 32'h0) begin bad++; $display("[TB] FAIL cont_status_clear: got %h want 0", v); end
    endtask

    task automatic test_wrap_flush();
        logic [31:0] v;
        logic        rv;
        int          lat;
        resetDut();
        instMode  = 0;
        instCount = 32'd100;
        regWrite(3'd2, 32'd5);
        cycCount = 32'hFFFF_FFFD;
        regWrite(3'd0, 32'd3);
        nextCycle();
        instCount = 32'd97;
        waitDone(20, lat);
        total++;
        if (lat !== 5) begin bad++; $display("[TB] FAIL wrap_latency: got %0d want 5", lat); end
        regRead(3'd3, v, rv);
        total++;
        if (v !== 32'd5) begin bad++; $display("[TB] FAIL wrap_win_cyc: got %h want 5", v); end
        regRead(3'd4, v, rv);
        total++;
        if (v !== 32'd0) begin bad++; $display("[TB] FAIL flush_win_inst: got %h want 0", v); end
    endtask

    task automatic test_same_cycle_status();
        logic [31:0] v;
        logic        rv;
        int          lat;
        resetDut();
        regWrite(3'd2, 32'd4);
        regWrite(3'd0, 32'd1);
        waitDone(20, lat);
        total++;
        if (lat !== 5) begin bad++; $display("[TB] FAIL sc_first: got %0d want 5", lat); end
        repeat (3) nextCycle();
        regRead(3'd1, v, rv);
        total++;
        if (v !== 32'h1 || winDone !== 1'b1) begin
            bad++;
            $display("[TB] FAIL sc_read_old: got %h done=%b want 1 done=1", v, winDone);
        end
        regWrite(3'd0, 32'd0);
        regRead(3'd1, v, rv);
        total++;
        if (v !== 32'h1) begin bad++; $display("[TB] FAIL sc_valid_kept: got %h want 1", v); end
        regRead(3'd1, v, rv);
        total++;
        if (v !== 32'h0) begin bad++; $display("[TB] FAIL sc_cleared: got %h want 0", v); end
    endtask

    task automatic test_stop_mid();
        logic [31:0] v;
        logic        rv;
        int          lat;
        int          d0;
        resetDut();
        regWrite(3'd2, 32'd10);
        d0 = doneCount;
        regWrite(3'd0, 32'd1);
        repeat (4) nextCycle();
        regWrite(3'd0, 32'd0);
        repeat (20) nextCycle();
        total++;
        if (doneCount !== d0) begin bad++; $display("[TB] FAIL stop_no_done: got %0d want %0d", doneCount, d0); end
        regRead(3'd3, v, rv);
        total++;
        if (v !== 32'd0) begin bad++; $display("[TB] FAIL stop_win_cyc: got %h want 0", v); end
        regRead(3'd1, v, rv);
        total++;
        if (v !== 32'd0) begin bad++; $display("[TB] FAIL stop_status: got %h want 0", v); end
        regWrite(3'd0, 32'd1);
        waitDone(30, lat);
        total++;
        if (lat !== 11) begin bad++; $display("[TB] FAIL stop_restart: got %0d want 11", lat); end
        regWrite(3'd0, 32'd0);
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        logic        rv;
        int          d0;
        resetDut();
        regWrite(3'd2, 32'd10);
        regWrite(3'd0, 32'd1);
        repeat (4) nextCycle();
        bus.rd_en = 1'b1;
        bus.addr  = 3'd2;
        nextCycle();
        bus.rd_en = 1'b0;
        d0 = doneCount;
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data !== 32'd0) begin
            bad++;
            $display("[TB] FAIL async_reset: got rv=%b rd=%h want 0 0", bus.rd_valid, bus.rd_data);
        end
        rst = 1'b0;
        repeat (20) nextCycle();
        total++;
        if (doneCount !== d0) begin bad++; $display("[TB] FAIL rst_no_done: got %0d want %0d", doneCount, d0); end
        regRead(3'd2, v, rv);
        total++;
        if (v !== 32'd1) begin bad++; $display("[TB] FAIL rst_win_len: got %h want 1", v); end
        regRead(3'd0, v, rv);
        total++;
        if (v !== 32'd0) begin bad++; $display("[TB] FAIL rst_ctrl: got %h want 0", v); end
        regRead(3'd3, v, rv);
        total++;
        if (v !== 32'd0) begin bad++; $display("[TB] FAIL rst_win_cyc: got %h want 0", v); end
    endtask

    task automatic test_perf_irq();
        logic [31:0] v;
        logic        rv;
        int          lat;
        resetDut();
        instMode = 2;
        regWrite(3'd6, 32'd5);
        regWrite(3'd2, 32'd6);
        regWrite(3'd0, 32'd3);
        waitDone(30, lat);
        total++;
        if (lat !== 7) begin bad++; $display("[TB] FAIL irq_latency: got %0d want 7", lat); end
        regRead(3'd4, v, rv);
        total++;
        if (v !== 32'd3) begin bad++; $display("[TB] FAIL irq_win_inst: got %h want 3", v); end
`ifdef PERF_IRQ_EN
        total++;
        if (perfIrq !== 1'b1) begin bad++; $display("[TB] FAIL irq_set: got %b want 1", perfIrq); end
        regRead(3'd1, v, rv);
        total++;
        if (perfIrq !== 1'b0) begin bad++; $display("[TB] FAIL irq_clear: got %b want 0", perfIrq); end
`else
        total++;
        if (perfIrq !== 1'b0) begin bad++; $display("[TB] FAIL irq_tied: got %b want 0", perfIrq); end
        regRead(3'd6, v, rv);
        total++;
        if (v !== 32'd0) begin bad++; $display("[TB] FAIL thresh_absent: got %h want 0", v); end
`endif
    endtask

    initial begin
        cycCount  = 32'h100;
        instCount = 32'h50;
        test_reset();
        test_regmap();
        test_oneshot();
        test_continuous();
        test_wrap_flush();
        test_same_cycle_status();
        test_stop_mid();
        test_reset_mid();
        test_perf_irq();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
